// File: rtl/axis_ram_sorter.sv
// Packet sorter: loads one AXI-stream packet into a register-array RAM, bubble-sorts it
// in place with early exit on a swap-free pass, then streams the sorted words out.
module axis_ram_sorter #(
    parameter int WIDTH   = 16,
    parameter int ADDRESS = 4,
    parameter bit SIGNED  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tvalid,
    output logic             tready,
    input  logic             tlast,
    input  logic [WIDTH-1:0] tdata,
    input  logic             desc,
    output logic             ovalid,
    input  logic             oready,
    output logic             olast,
    output logic [WIDTH-1:0] odata,
    output logic             busy,
    output logic             overflow
);
    // state | meaning
    // LOAD  | accepting input beats into ram[wr]
    // SORT  | one compare-and-swap of ram[idx], ram[idx+1] per cycle
    // DRAIN | streaming ram[rd] until the olast beat is accepted
    localparam int DEPTH = 2 ** ADDRESS;

    typedef logic [ADDRESS:0] cnt_t;
    localparam cnt_t LAST_ADDR = cnt_t'(DEPTH - 1);
    localparam cnt_t ONE       = cnt_t'(1);
    localparam cnt_t TWO       = cnt_t'(2);

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] ram [DEPTH];
    cnt_t             wr, rd, length, idx, pass;
    logic             dir, swapped;

    logic               load_beat, drain_ack, rd_last;
    logic               pass_end, sort_done, do_swap, gt, lt;
    logic [ADDRESS-1:0] addr_a, addr_b;
    logic [WIDTH-1:0]   word_a, word_b;

    assign load_beat = (state == LOAD) && tvalid && !reset;
    assign drain_ack = (state == DRAIN) && oready;
    assign rd_last   = (rd == length - ONE);
    assign addr_a    = idx[ADDRESS-1:0];
    assign addr_b    = addr_a + ADDRESS'(1);
    assign word_a    = ram[addr_a];
    assign word_b    = ram[addr_b];

    always_comb begin
        if (SIGNED) begin
            gt = $signed(word_a) > $signed(word_b);
            lt = $signed(word_a) < $signed(word_b);
        end else begin
            gt = word_a > word_b;
            lt = word_a < word_b;
        end
    end

    // A single-word packet needs no compare, so it leaves SORT after one cycle.
    assign do_swap   = (state == SORT) && (length != ONE) && (dir ? lt : gt);
    assign pass_end  = (idx == length - TWO);
    assign sort_done = (length == ONE) ||
                       (pass_end && (!(swapped || do_swap) || pass == length - TWO));

    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tready    = 1'b0;
        ovalid    = 1'b0;
        olast     = 1'b0;
        odata     = '0;
        busy      = 1'b0;
        overflow  = 1'b0;
        case (state)
            LOAD: begin
                tready = !reset;
                if (load_beat) begin
                    if (tlast) begin
                        state_nxt = SORT;
                    end else if (wr == LAST_ADDR) begin
                        state_nxt = SORT;
                        overflow  = 1'b1;
                    end
                end
            end
            SORT: begin
                busy = 1'b1;
                if (sort_done) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy   = 1'b1;
                ovalid = 1'b1;
                odata  = ram[rd[ADDRESS-1:0]];
                olast  = rd_last;
                if (drain_ack && rd_last) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr      <= '0;
            rd      <= '0;
            length  <= '0;
            idx     <= '0;
            pass    <= '0;
            dir     <= 1'b0;
            swapped <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (load_beat) begin
                        wr <= wr + ONE;
                        if (tlast || wr == LAST_ADDR) begin
                            length  <= wr + ONE;
                            dir     <= desc;
                            idx     <= '0;
                            pass    <= '0;
                            swapped <= 1'b0;
                        end
                    end
                end
                SORT: begin
                    if (!sort_done) begin
                        if (pass_end) begin
                            idx     <= '0;
                            pass    <= pass + ONE;
                            swapped <= 1'b0;
                        end else begin
                            idx     <= idx + ONE;
                            swapped <= swapped || do_swap;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_ack) begin
                        if (rd_last) begin
                            wr     <= '0;
                            rd     <= '0;
                            length <= '0;
                        end else begin
                            rd <= rd + ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM is deliberately not reset; words beyond length are never read out.
    always_ff @(posedge clk) begin
        if (load_beat) begin
            ram[wr[ADDRESS-1:0]] <= tdata;
        end else if (do_swap) begin
            ram[addr_a] <= word_b;
            ram[addr_b] <= word_a;
        end
    end
endmodule

// File: tb/tb_axis_ram_sorter.sv
// Self-checking bench for axis_ram_sorter: an unsigned 16-bit/16-deep instance and a
// signed 8-bit/4-deep instance, checked against a scoreboard of stably sorted packets.
module tb_axis_ram_sorter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, tvalid, tlast, desc, oready, sel;
    logic [15:0] tdata;

    logic        u_tvalid, u_tready, u_ovalid, u_olast, u_busy, u_overflow;
    logic [15:0] u_odata;
    logic        s_tvalid, s_tready, s_ovalid, s_olast, s_busy, s_overflow;
    logic [7:0]  s_odata;
    logic        m_tready, m_ovalid, m_olast, m_busy, m_overflow;
    logic [15:0] m_odata;

    assign u_tvalid   = tvalid & ~sel;
    assign s_tvalid   = tvalid & sel;
    assign m_tready   = sel ? s_tready   : u_tready;
    assign m_ovalid   = sel ? s_ovalid   : u_ovalid;
    assign m_olast    = sel ? s_olast    : u_olast;
    assign m_busy     = sel ? s_busy     : u_busy;
    assign m_overflow = sel ? s_overflow : u_overflow;
    assign m_odata    = sel ? {8'h00, s_odata} : u_odata;

    axis_ram_sorter #(.WIDTH(16), .ADDRESS(4), .SIGNED(1'b0)) dut_u (
        .clk(clk), .reset(reset), .tvalid(u_tvalid), .tready(u_tready), .tlast(tlast),
        .tdata(tdata), .desc(desc), .ovalid(u_ovalid), .oready(oready), .olast(u_olast),
        .odata(u_odata), .busy(u_busy), .overflow(u_overflow));

    axis_ram_sorter #(.WIDTH(8), .ADDRESS(2), .SIGNED(1'b1)) dut_s (
        .clk(clk), .reset(reset), .tvalid(s_tvalid), .tready(s_tready), .tlast(tlast),
        .tdata(tdata[7:0]), .desc(desc), .ovalid(s_ovalid), .oready(oready), .olast(s_olast),
        .odata(s_odata), .busy(s_busy), .overflow(s_overflow));

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] pkt[$];

    function automatic int key(input logic [15:0] v);
        if (sel) return int'($signed(v[7:0]));
        return int'(v);
    endfunction

    // Reference: stable insertion sort, then queue the words with their olast flag.
    task automatic push_expected(input logic [15:0] w[$], input bit dsc);
        logic [15:0] s[$];
        logic [15:0] t;
        int          j;
        s = w;
        for (int i = 1; i < s.size(); i++) begin
            j = i;
            while (j > 0 && (dsc ? key(s[j-1]) < key(s[j]) : key(s[j-1]) > key(s[j]))) begin
                t = s[j-1]; s[j-1] = s[j]; s[j] = t;
                j--;
            end
        end
        for (int k = 0; k < s.size(); k++)
            sb.push_back('{data: s[k], last: (k == s.size() - 1)});
    endtask

    task automatic load_pkt(input string name, input logic [15:0] w[$], input bit with_last,
                            input int ovf_at);
        int   wait_cyc;
        logic exp_ovf;
        for (int i = 0; i < w.size(); i++) begin
            tvalid = 1'b1;
            tdata  = w[i];
            tlast  = with_last && (i == w.size() - 1);
            @(negedge clk);
            wait_cyc = 0;
            while (!m_tready && wait_cyc < 500) begin
                @(posedge clk); #1;
                @(negedge clk);
                wait_cyc++;
            end
            n_cmp++;
            if (m_tready !== 1'b1) begin
                n_bad++;
                $display("FAIL %s load_ready beat %0d: tready=%b required 1", name, i, m_tready);
            end
            exp_ovf = (i == ovf_at);
            n_cmp++;
            if (m_overflow !== exp_ovf) begin
                n_bad++;
                $display("FAIL %s overflow beat %0d: got %b required %b", name, i, m_overflow, exp_ovf);
            end
            @(posedge clk); #1;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic measure_sort(input string name, input int exp_s);
        int cnt = 0;
        int cyc = 0;
        oready = 1'b0;
        @(negedge clk);
        while (!m_ovalid && cyc < 1000) begin
            if (m_busy) cnt++;
            cyc++;
            @(negedge clk);
        end
        n_cmp++;
        if (m_ovalid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ovalid_timeout: ovalid=%b required 1", name, m_ovalid);
        end
        n_cmp++;
        if (cnt != exp_s) begin
            n_bad++;
            $display("FAIL %s sort_cycles: got %0d required %0d", name, cnt, exp_s);
        end
    endtask

    // mode 0: oready held high; mode 1: oready toggles every cycle.
    task automatic drain(input string name, input int mode, input int max_beats);
        int          cyc = 0;
        int          got = 0;
        logic        stalled = 1'b0;
        logic [15:0] hd = '0;
        logic        hl = 1'b0;
        exp_t        e;
        while (sb.size() > 0 && got < max_beats && cyc < 500) begin
            @(posedge clk); #1;
            oready = (mode == 0) ? 1'b1 : ~oready;
            @(negedge clk);
            cyc++;
            if (stalled) begin
                n_cmp++;
                if (m_odata !== hd || m_olast !== hl) begin
                    n_bad++;
                    $display("FAIL %s stall_hold: odata=%h olast=%b required %h %b",
                             name, m_odata, m_olast, hd, hl);
                end
            end
            if (m_ovalid && oready) begin
                e = sb.pop_front();
                got++;
                n_cmp++;
                if (m_odata !== e.data || m_olast !== e.last) begin
                    n_bad++;
                    $display("FAIL %s out_beat %0d: odata=%h olast=%b required %h %b",
                             name, got - 1, m_odata, m_olast, e.data, e.last);
                end
            end
            stalled = m_ovalid && !oready;
            hd      = m_odata;
            hl      = m_olast;
        end
        n_cmp++;
        if (sb.size() > 0 && got < max_beats) begin
            n_bad++;
            $display("FAIL %s drain_timeout: got %0d beats, %0d still expected", name, got, sb.size());
        end
        @(posedge clk); #1;
        oready = 1'b0;
        if (sb.size() == 0) begin
            @(negedge clk);
            n_cmp++;
            if (m_tready !== 1'b1 || m_ovalid !== 1'b0 || m_odata !== 16'h0 ||
                m_olast !== 1'b0 || m_busy !== 1'b0) begin
                n_bad++;
                $display("FAIL %s post_drain: tready=%b ovalid=%b odata=%h olast=%b busy=%b required 1 0 0000 0 0",
                         name, m_tready, m_ovalid, m_odata, m_olast, m_busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run_pkt(input string name, input logic [15:0] w[$], input bit with_last,
                           input bit dsc, input int ovf_at, input int exp_s, input int mode);
        desc = dsc;
        push_expected(w, dsc);
        load_pkt(name, w, with_last, ovf_at);
        measure_sort(name, exp_s);
        drain(name, mode, 1000);
    endtask

    task automatic test_reset();
        reset = 1'b1; tvalid = 1'b1; tlast = 1'b1; tdata = 16'hBEEF;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if (m_tready !== 1'b0 || m_overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_in: tready=%b overflow=%b required 0 0", m_tready, m_overflow);
        end
        n_cmp++;
        if (m_ovalid !== 1'b0 || m_olast !== 1'b0 || m_odata !== 16'h0 || m_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out: ovalid=%b olast=%b odata=%h busy=%b required 0 0 0000 0",
                     m_ovalid, m_olast, m_odata, m_busy);
        end
        @(posedge clk); #1;
        reset = 1'b0; tvalid = 1'b0; tlast = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (m_tready !== 1'b1 || m_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: tready=%b busy=%b required 1 0", m_tready, m_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ascending();
        pkt = '{16'd5, 16'd3, 16'd9, 16'd1};
        run_pkt("ascending", pkt, 1'b1, 1'b0, -1, 9, 0);
    endtask

    task automatic test_stable();
        pkt = '{16'd3, 16'd7, 16'd7};
        run_pkt("stable", pkt, 1'b1, 1'b0, -1, 2, 0);
    endtask

    task automatic test_signed_desc();
        sel = 1'b1;
        pkt = '{16'h00FF, 16'h0002, 16'h0080, 16'h0000};
        run_pkt("signed_desc", pkt, 1'b1, 1'b1, -1, 9, 0);
        sel = 1'b0;
    endtask

    task automatic test_early_exit();
        pkt.delete();
        for (int i = 1; i <= 16; i++) pkt.push_back(16'(i));
        run_pkt("early_exit", pkt, 1'b1, 1'b0, -1, 15, 0);
    endtask

    task automatic test_overflow();
        pkt.delete();
        for (int i = 16; i >= 1; i--) pkt.push_back(16'(i));
        run_pkt("overflow", pkt, 1'b0, 1'b0, 15, 225, 0);
        pkt = '{16'd100, 16'd50};
        run_pkt("overflow_next", pkt, 1'b1, 1'b0, -1, 1, 0);
    endtask

    task automatic test_single();
        pkt = '{16'h1234};
        run_pkt("single", pkt, 1'b1, 1'b0, -1, 1, 0);
    endtask

    task automatic test_backpressure();
        pkt = '{16'd10, 16'd40, 16'd20, 16'd30};
        run_pkt("backpressure", pkt, 1'b1, 1'b1, -1, 9, 1);
    endtask

    task automatic test_reset_drain();
        desc = 1'b0;
        pkt  = '{16'd4, 16'd3, 16'd2, 16'd1};
        push_expected(pkt, 1'b0);
        load_pkt("reset_drain", pkt, 1'b1, -1);
        measure_sort("reset_drain", 9);
        drain("reset_drain", 0, 2);
        reset  = 1'b1;
        oready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (m_ovalid !== 1'b0 || m_tready !== 1'b1 || m_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_drain_abort: ovalid=%b tready=%b busy=%b required 0 1 0",
                     m_ovalid, m_tready, m_busy);
        end
        sb.delete();
        @(posedge clk); #1;
        pkt = '{16'd2, 16'd1};
        run_pkt("after_reset", pkt, 1'b1, 1'b0, -1, 1, 0);
    endtask

    initial begin
        sel = 1'b0; reset = 1'b1; tvalid = 1'b0; tlast = 1'b0;
        tdata = '0; desc = 1'b0; oready = 1'b0;
        test_reset();
        test_ascending();
        test_stable();
        test_signed_desc();
        test_early_exit();
        test_overflow();
        test_single();
        test_backpressure();
        test_reset_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
